// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the ID-stage hazard detection unit.
// Holds the FSM state encoding, the MemRead "no load" encoding, the
// hard-wired zero register and the operand/destination match helper.
package hazard_detection_unit_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hdu_state_e;

  localparam logic [1:0] MEMREAD_NONE = 2'b00;
  localparam logic [4:0] REG_ZERO     = 5'd0;

  // An operand hazards against a destination only if the instruction
  // actually reads it and the destination is not $0 (writes to $0 vanish).
  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_compare.sv
// hazard_compare: pure combinational classifier of ID-stage hazards.
// Ports: ID source fields/usage flags and branch flag, EX and MEM destination
//   and load info in; lu_o (load-use), be_o (branch on EX ALU result), bm_o (branch on MEM load) out.
module hazard_compare
  import hazard_detection_unit_pkg::*;
(
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       uses_rs_i,
  input  logic       uses_rt_i,
  input  logic       branch_op_i,
  input  logic [1:0] idex_memread_i,
  input  logic       idex_regwrite_i,
  input  logic [4:0] idex_writereg_i,
  input  logic [1:0] exmem_memread_i,
  input  logic [4:0] exmem_writereg_i,
  output logic       lu_o,
  output logic       be_o,
  output logic       bm_o
);

  logic match_ex;
  logic match_mem;

  assign match_ex  = reg_match(uses_rs_i, ifid_rs_i, idex_writereg_i) ||
                     reg_match(uses_rt_i, ifid_rt_i, idex_writereg_i);
  assign match_mem = reg_match(uses_rs_i, ifid_rs_i, exmem_writereg_i) ||
                     reg_match(uses_rt_i, ifid_rt_i, exmem_writereg_i);

  assign lu_o = (idex_memread_i != MEMREAD_NONE) && match_ex;
  // An ALU result in EX is not yet forwardable to the ID comparator.
  assign be_o = branch_op_i && idex_regwrite_i &&
                (idex_memread_i == MEMREAD_NONE) && match_ex;
  assign bm_o = branch_op_i && (exmem_memread_i != MEMREAD_NONE) && match_mem;

endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: ID-stage stall/flush control with stall and flush counters.
// Ports: Clk/Rst, IF/ID source info, ID/EX and EX/MEM destination info, Hold in;
//   ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush (combinational), StallCount, FlushCount out.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_BranchOp,
  input  logic             ID_Taken,
  input  logic [1:0]       IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_WriteReg,
  input  logic [1:0]       EXMEM_MemRead,
  input  logic [4:0]       EXMEM_WriteReg,
  input  logic             Hold,
  output logic             ControlMuxSignal,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  hdu_state_e       state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic lu, be, bm;
  // Pre-reset-gating versions of the outputs; these also drive the
  // registered state so the reset net never enters a D path.
  logic cm_core, pcw_core, ifw_core, flush_core;

  hazard_compare u_cmp (
    .ifid_rs_i        (IFID_Rs),
    .ifid_rt_i        (IFID_Rt),
    .uses_rs_i        (ID_UsesRs),
    .uses_rt_i        (ID_UsesRt),
    .branch_op_i      (ID_BranchOp),
    .idex_memread_i   (IDEX_MemRead),
    .idex_regwrite_i  (IDEX_RegWrite),
    .idex_writereg_i  (IDEX_WriteReg),
    .exmem_memread_i  (EXMEM_MemRead),
    .exmem_writereg_i (EXMEM_WriteReg),
    .lu_o             (lu),
    .be_o             (be),
    .bm_o             (bm)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cm_core    = 1'b1;
    pcw_core   = 1'b1;
    ifw_core   = 1'b1;
    flush_core = 1'b0;
    if (Hold) begin
      // Freeze everything without injecting a bubble.
      pcw_core = 1'b0;
      ifw_core = 1'b0;
    end else if (state_q == ST_STALL) begin
      cm_core  = 1'b0;
      pcw_core = 1'b0;
      ifw_core = 1'b0;
      if (rem_q <= 2'd1) begin
        state_d = ST_RUN;
        rem_d   = 2'd0;
      end else begin
        rem_d = rem_q - 2'd1;
      end
    end else if (lu || be || bm) begin
      cm_core  = 1'b0;
      pcw_core = 1'b0;
      ifw_core = 1'b0;
      // A branch waiting on a load needs the value out of MEM: two bubbles.
      if (lu && ID_BranchOp) begin
        state_d = ST_STALL;
        rem_d   = 2'd1;
      end
    end else begin
      flush_core = ID_Taken;
    end
  end

  assign ControlMuxSignal = Rst & cm_core;
  assign PCWrite          = Rst & pcw_core;
  assign IFIDWrite        = Rst & ifw_core;
  assign IFIDFlush        = Rst & flush_core;
  assign StallCount       = stall_cnt_q;
  assign FlushCount       = flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (!cm_core && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_core && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_WriteReg, EXMEM_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_BranchOp, ID_Taken, IDEX_RegWrite, Hold;
  logic [1:0]  IDEX_MemRead, EXMEM_MemRead;
  logic        ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush;
  logic [31:0] StallCount, FlushCount;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: outstanding extra bubbles and event tallies.
  int          m_pend;
  logic [31:0] m_stalls, m_flushes;

  hazard_detection_unit #(.CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_BranchOp(ID_BranchOp), .ID_Taken(ID_Taken),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WriteReg(IDEX_WriteReg),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WriteReg(EXMEM_WriteReg),
    .Hold(Hold),
    .ControlMuxSignal(ControlMuxSignal), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  function automatic bit hits(input logic [4:0] d);
    return (d != 5'd0) && ((ID_UsesRs && IFID_Rs == d) || (ID_UsesRt && IFID_Rt == d));
  endfunction

  // Bubbles the current ID instruction needs, from the hazard rules.
  function automatic int need_f();
    int n = 0;
    if (IDEX_MemRead != 2'd0 && hits(IDEX_WriteReg)) n = ID_BranchOp ? 2 : 1;
    if (ID_BranchOp && IDEX_RegWrite && IDEX_MemRead == 2'd0 && hits(IDEX_WriteReg) && n < 1) n = 1;
    if (ID_BranchOp && EXMEM_MemRead != 2'd0 && hits(EXMEM_WriteReg) && n < 1) n = 1;
    return n;
  endfunction

  // Expected {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}.
  function automatic logic [3:0] exp_f();
    if (!Rst) return 4'b0000;
    if (Hold) return 4'b1000;
    if (m_pend > 0 || need_f() > 0) return 4'b0000;
    return {3'b111, ID_Taken};
  endfunction

  task automatic model_edge();
    int n;
    if (!Rst || Hold) return;
    if (m_pend > 0) begin
      m_pend--;
      if (m_stalls != 32'hFFFF_FFFF) m_stalls++;
    end else begin
      n = need_f();
      if (n > 0) begin
        if (m_stalls != 32'hFFFF_FFFF) m_stalls++;
        m_pend = n - 1;
      end else if (ID_Taken) begin
        if (m_flushes != 32'hFFFF_FFFF) m_flushes++;
      end
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic clr_in();
    IFID_Rs = 0; IFID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_BranchOp = 0; ID_Taken = 0;
    IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
    EXMEM_MemRead = 0; EXMEM_WriteReg = 0; Hold = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge Clk);
    Rst = 1'b0;
    #1 Rst = 1'b1;
    model_reset();
    clr_in();
    tick();
  endtask

  task automatic set_load_ex(input logic [4:0] d);
    IDEX_MemRead = 2'b01; IDEX_RegWrite = 1'b1; IDEX_WriteReg = d;
  endtask

  task automatic test_reset();
    clr_in();
    Rst = 1'b0;
    ID_Taken = 1'b1;
    #3;
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outs got=%b want=0000", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush});
    end
    n_cmp++;
    if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", StallCount, FlushCount);
    end
    @(negedge Clk);
    Rst = 1'b1;
    model_reset();
    clr_in();
    tick();
  endtask

  task automatic test_load_use();
    rst_pulse();
    set_load_ex(5'd8); IFID_Rs = 5'd8; ID_UsesRs = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b0000) begin
      n_fail++; $display("FAIL lu_bubble got=%b want=0000", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush});
    end
    tick();
    clr_in();
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1110 || StallCount !== 32'd1) begin
      n_fail++; $display("FAIL lu_after got=%b cnt=%0d want=1110 cnt=1", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount);
    end
    tick();
  endtask

  task automatic test_branch_load();
    rst_pulse();
    set_load_ex(5'd8); IFID_Rt = 5'd8; ID_UsesRt = 1'b1; ID_BranchOp = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      n_cmp++;
      if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b0000) begin
        n_fail++; $display("FAIL brlu_bubble%0d got=%b want=0000", c, {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush});
      end
      tick();
    end
    clr_in();
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1110 || StallCount !== 32'd2) begin
      n_fail++; $display("FAIL brlu_after got=%b cnt=%0d want=1110 cnt=2", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount);
    end
    tick();
  endtask

  task automatic test_branch_alu();
    rst_pulse();
    IDEX_RegWrite = 1'b1; IDEX_WriteReg = 5'd9; IFID_Rs = 5'd9; ID_UsesRs = 1'b1; ID_BranchOp = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ControlMuxSignal !== 1'b0) begin
      n_fail++; $display("FAIL be_bubble got=%b want=0", ControlMuxSignal);
    end
    tick();
    IDEX_WriteReg = 5'd0; IFID_Rs = 5'd0;
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1110 || StallCount !== 32'd1) begin
      n_fail++; $display("FAIL be_zero got=%b cnt=%0d want=1110 cnt=1", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount);
    end
    tick();
    clr_in();
    ID_BranchOp = 1'b1; EXMEM_MemRead = 2'b10; EXMEM_WriteReg = 5'd5; IFID_Rt = 5'd5; ID_UsesRt = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ControlMuxSignal !== 1'b0 || PCWrite !== 1'b0) begin
      n_fail++; $display("FAIL bm_bubble got=%b%b want=00", ControlMuxSignal, PCWrite);
    end
    tick();
    ID_UsesRt = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (ControlMuxSignal !== 1'b1 || StallCount !== 32'd2) begin
      n_fail++; $display("FAIL bm_unused got=%b cnt=%0d want=1 cnt=2", ControlMuxSignal, StallCount);
    end
    tick();
  endtask

  task automatic test_flush();
    rst_pulse();
    ID_Taken = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1111) begin
      n_fail++; $display("FAIL flush_taken got=%b want=1111", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush});
    end
    tick();
    set_load_ex(5'd3); IFID_Rs = 5'd3; ID_UsesRs = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b0000 || FlushCount !== 32'd1) begin
      n_fail++; $display("FAIL flush_vs_stall got=%b fc=%0d want=0000 fc=1", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, FlushCount);
    end
    tick();
    clr_in();
    @(negedge Clk);
    n_cmp++;
    if (FlushCount !== 32'd1 || StallCount !== 32'd1) begin
      n_fail++; $display("FAIL flush_cnt got=%0d/%0d want=1/1", FlushCount, StallCount);
    end
    tick();
  endtask

  task automatic test_hold_stall();
    rst_pulse();
    set_load_ex(5'd8); IFID_Rt = 5'd8; ID_UsesRt = 1'b1; ID_BranchOp = 1'b1;
    tick();
    Hold = 1'b1; ID_Taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      n_cmp++;
      if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1000 || StallCount !== 32'd1) begin
        n_fail++; $display("FAIL hold%0d got=%b cnt=%0d want=1000 cnt=1", c, {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount);
      end
      tick();
    end
    Hold = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b0000) begin
      n_fail++; $display("FAIL hold_resume got=%b want=0000", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush});
    end
    tick();
    clr_in();
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1110 || StallCount !== 32'd2) begin
      n_fail++; $display("FAIL hold_done got=%b cnt=%0d want=1110 cnt=2", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    rst_pulse();
    set_load_ex(5'd4); IFID_Rs = 5'd4; ID_UsesRs = 1'b1; ID_BranchOp = 1'b1;
    tick();
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b0000 || StallCount !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid got=%b cnt=%0d/%0d want=0000 0/0", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount, FlushCount);
    end
    #1 Rst = 1'b1;
    model_reset();
    clr_in();
    tick();
    @(negedge Clk);
    n_cmp++;
    if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== 4'b1110 || StallCount !== 32'd0) begin
      n_fail++; $display("FAIL rst_run got=%b cnt=%0d want=1110 cnt=0", {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush}, StallCount);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] e;
    rst_pulse();
    for (int c = 0; c < 400; c++) begin
      IFID_Rs = 5'($urandom_range(0, 3)); IFID_Rt = 5'($urandom_range(0, 3));
      ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom);
      ID_BranchOp = 1'($urandom); ID_Taken = 1'($urandom);
      IDEX_MemRead = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      IDEX_RegWrite = 1'($urandom); IDEX_WriteReg = 5'($urandom_range(0, 3));
      EXMEM_MemRead = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      EXMEM_WriteReg = 5'($urandom_range(0, 3));
      Hold = ($urandom_range(0, 7) == 0);
      @(negedge Clk);
      e = exp_f();
      n_cmp++;
      if ({ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush} !== e || StallCount !== m_stalls || FlushCount !== m_flushes) begin
        n_fail++;
        $display("FAIL rand%0d got=%b %0d/%0d want=%b %0d/%0d", c, {ControlMuxSignal, PCWrite, IFIDWrite, IFIDFlush},
                 StallCount, FlushCount, e, m_stalls, m_flushes);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_flush();
    test_hold_stall();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
